debounce_edge: RTL and testbench
================================

# debounce_edge

Input conditioner that sits directly upstream of the `dff`/`tff`/`jkff` storage elements. Takes a raw, asynchronous, possibly bouncing 1-bit input (switch, button, external strobe) and synchronizes it into the `clk` domain. It filters out pulses shorter than a programmable stability window. It outputs a clean level plus single-cycle rise/fall pulses, so a downstream `tff` can be driven with `t = rise` and toggle exactly once per press.

## Interface
- `SYNC_STAGES`, default 2: synchronizer depth, legal range 2..4.
- `STABLE_CYCLES`, default 4: consecutive synchronized samples required before `level` changes, legal range 1..65535.
- `clk`  input  1: single clock; all state updates on posedge.
- `reset_n`  input  1: asynchronous, active-low reset; it asserts immediately and is released synchronously by the system.
- `din`  input  1: raw asynchronous input; no timing relationship to `clk`.
- `level`  output  1: debounced, synchronized version of `din`.
- `rise`  output  1: one-cycle pulse, high in the first cycle `level` is 1 after being 0.
- `fall`  output  1: one-cycle pulse, high in the first cycle `level` is 0 after being 1.
- `busy`  output  1: high while a candidate change is being qualified.

## Operation
- Synchronizer: a chain of `SYNC_STAGES` flops clocked by `clk`, all reset to 0. Its last stage is `s`. No logic between stages.
- Counter `cnt`: width `max(1, $clog2(STABLE_CYCLES))`, unsigned, reset to 0. It never exceeds `STABLE_CYCLES-1` and never wraps.
- FSM, two states, registered:
  - IDLE: entered when `s == level`; `cnt` held at 0.
  - QUALIFY: entered when `s != level`.
- Per posedge, evaluated with the pre-edge values:
  - If `s == level`: `cnt <= 0`, state becomes IDLE. This covers an abort mid-qualification, where a glitch shorter than the window is discarded with no output change.
  - Else if `cnt == STABLE_CYCLES-1`: `level <= s`, `cnt <= 0`, state becomes IDLE, and `rise <= s` / `fall <= ~s`.
  - Else: `cnt <= cnt + 1`, state becomes QUALIFY.
- `rise` and `fall` are registered, default 0 every cycle unless set by the commit branch above.
  - They are never high simultaneously.
  - Each is high for exactly one cycle per `level` transition.
- `busy` = (state == QUALIFY); it is registered, not decoded from `s`.
- Reset (`reset_n` low, any time): synchronizer, `cnt`, state, `level`, `rise`, `fall` and `busy` all go to 0 immediately.
  - An in-progress qualification is dropped with no pulse.
  - A pulse already high is cleared at once.
- Out-of-range parameters are rejected at elaboration with a `$error`.

## Timing
- Reset values: `level`=0, `rise`=0, `fall`=0, `busy`=0.
- Latency: assume `din` changes and then stays stable, with setup met before posedge E1.
  - `s` reflects the change after edge E(`SYNC_STAGES`).
  - `level`, and the matching `rise` or `fall`, update on edge E(`SYNC_STAGES + STABLE_CYCLES`).
  - With defaults this is edge E6.
- `busy` rises on edge E(`SYNC_STAGES`+1) and falls on the commit edge. If `STABLE_CYCLES`=1, `busy` never asserts.
- Rejection rule: any `s` pulse lasting fewer than `STABLE_CYCLES` cycles produces no change on `level`, `rise` or `fall`.
- Spacing: the minimum spacing between consecutive `rise` pulses is 2×`STABLE_CYCLES` cycles.
- `din` held high through reset release: this is treated as a 0→1 transition, so `rise` fires on edge E(`SYNC_STAGES + STABLE_CYCLES`) after release.
- Metastability: only the first synchronizer flop samples `din`. Benches treat `s` as valid after `SYNC_STAGES` edges.

## Test plan
- Clean press, defaults:
  - `din` 0→1 before E1 and held → `level` 1 and `rise` 1 for exactly one cycle at E6.
  - `busy` high E3..E5.
  - `fall` stays 0.
- Bounce rejection: `din` toggles high 2 cycles, low 1, high 3, low; every `s` run is < 4 cycles → `level`, `rise` and `fall` stay 0 throughout; `busy` pulses and returns to 0.
- Release after press: from `level`=1, `din` 1→0 before E1 → `level`=0 and `fall`=1 for one cycle at E6; `rise`=0.
- Reset mid-qualification: `din` 0→1, `reset_n` low for one cycle at E4 and released → all outputs 0 immediately, no `rise` at E6. `rise` occurs 6 edges after release.
- `STABLE_CYCLES`=1, `SYNC_STAGES`=3: `din` 0→1 before E1 → `level`/`rise` at E4; `busy` never 1.
- Downstream check: `rise` drives `tff.t`; 3 clean presses separated by 20 cycles → `tff.q` toggles exactly 3 times, ending at 1.

Source files
------------

// File: rtl/debounce_edge.sv
// debounce_edge: synchronizes a raw asynchronous input into the clk domain and
// debounces it. It produces a clean level plus one-cycle rise and fall pulses.
//
// Ports:
//   clk     - single clock, all state updates on posedge
//   reset_n - asynchronous active-low reset
//   din     - raw asynchronous input (may bounce)
//   level   - debounced, synchronized version of din
//   rise    - one-cycle pulse on the first cycle level is 1 after being 0
//   fall    - one-cycle pulse on the first cycle level is 0 after being 1
//   busy    - high while a candidate change is being qualified
module debounce_edge #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam int unsigned CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_QUALIFY = 1'b1
  } state_e;

  // Reject out-of-range parameters at elaboration
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("debounce_edge: SYNC_STAGES=%0d outside 2..4", SYNC_STAGES);
  end
  if (STABLE_CYCLES < 1 || STABLE_CYCLES > 65535) begin : g_bad_stable
    $error("debounce_edge: STABLE_CYCLES=%0d outside 1..65535", STABLE_CYCLES);
  end

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  state_e                 state_q, state_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   busy_q, busy_d;
  logic                   s;

  // Last synchronizer stage is the only value the qualifier looks at
  assign s = sync_q[SYNC_STAGES-1];

  // Next-state: abort on agreement, commit after the window, else keep counting
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], din};
    cnt_d   = '0;
    state_d = ST_IDLE;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (s == level_q) begin
      cnt_d   = '0;
      state_d = ST_IDLE;
    end else if (cnt_q == CNT_MAX) begin
      level_d = s;
      rise_d  = s;
      fall_d  = ~s;
    end else begin
      cnt_d   = cnt_q + CNT_W'(1);
      state_d = ST_QUALIFY;
    end
    // busy is registered alongside state so it mirrors the state register
    busy_d = (state_d == ST_QUALIFY);
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      state_q <= ST_IDLE;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_debounce_edge.sv
// Testbench for debounce_edge. Expected rise/fall events are queued by the
// stimulus with the cycle they must appear on. Monitors pop and compare them
// whenever a DUT emits a pulse.
module tb_debounce_edge;

  typedef struct packed {
    logic        is_rise;
    logic [31:0] cyc;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n;
  logic din_a, din_b;
  logic level_a, rise_a, fall_a, busy_a;
  logic level_b, rise_b, fall_b, busy_b;

  int unsigned cyc = 0;
  int total = 0;
  int bad   = 0;

  ev_t sb_a[$];
  ev_t sb_b[$];

  // Downstream toggle flop driven by rise
  logic tff_q;
  int   tff_toggles;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  debounce_edge #(.SYNC_STAGES(2), .STABLE_CYCLES(4)) u_dut_a (
    .clk(clk), .reset_n(rst_n), .din(din_a),
    .level(level_a), .rise(rise_a), .fall(fall_a), .busy(busy_a)
  );

  debounce_edge #(.SYNC_STAGES(3), .STABLE_CYCLES(1)) u_dut_b (
    .clk(clk), .reset_n(rst_n), .din(din_b),
    .level(level_b), .rise(rise_b), .fall(fall_b), .busy(busy_b)
  );

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tff_q       <= 1'b0;
      tff_toggles <= 0;
    end else if (rise_a) begin
      tff_q       <= ~tff_q;
      tff_toggles <= tff_toggles + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor for instance A
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (rise_a === 1'b1 || fall_a === 1'b1)) begin
      ev_t e;
      check("a_rise_fall_exclusive", 32'(rise_a & fall_a), 32'd0);
      if (sb_a.size() == 0) begin
        check("a_unexpected_pulse", {31'd0, rise_a}, 32'd2);
      end else begin
        e = sb_a.pop_front();
        check("a_pulse_kind", {31'd0, rise_a}, {31'd0, e.is_rise});
        check("a_pulse_cycle", cyc, e.cyc);
        check("a_level_at_pulse", {31'd0, level_a}, {31'd0, e.is_rise});
      end
    end
  end

  // Monitor for instance B
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (rise_b === 1'b1 || fall_b === 1'b1)) begin
      ev_t e;
      check("b_rise_fall_exclusive", 32'(rise_b & fall_b), 32'd0);
      if (sb_b.size() == 0) begin
        check("b_unexpected_pulse", {31'd0, rise_b}, 32'd2);
      end else begin
        e = sb_b.pop_front();
        check("b_pulse_kind", {31'd0, rise_b}, {31'd0, e.is_rise});
        check("b_pulse_cycle", cyc, e.cyc);
        check("b_level_at_pulse", {31'd0, level_b}, {31'd0, e.is_rise});
      end
    end
  end

  // Bounded wait for all queued events to be consumed
  task automatic drain(input string name);
    for (int i = 0; i < 40; i++) begin
      if (sb_a.size() == 0 && sb_b.size() == 0) break;
      @(negedge clk);
    end
    check(name, 32'(sb_a.size() + sb_b.size()), 32'd0);
  endtask

  // Step din_a and watch busy/level for 7 edges against the default latency
  task automatic clean_step(input logic val, input string tag);
    int unsigned base;
    ev_t e;
    din_a = val;
    base  = cyc;
    e.is_rise = val;
    e.cyc     = base + 6;
    sb_a.push_back(e);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      check({tag, "_busy"}, {31'd0, busy_a}, (k >= 3 && k <= 5) ? 32'd1 : 32'd0);
      check({tag, "_level"}, {31'd0, level_a}, (k >= 6) ? {31'd0, val} : {31'd0, ~val});
    end
  endtask

  initial begin
    int unsigned base;
    int          busy_seen;
    ev_t         e;

    rst_n = 1'b0;
    din_a = 1'b0;
    din_b = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_level", {31'd0, level_a}, 32'd0);
    check("reset_rise",  {31'd0, rise_a},  32'd0);
    check("reset_fall",  {31'd0, fall_a},  32'd0);
    check("reset_busy",  {31'd0, busy_a},  32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Clean press then release with default parameters
    clean_step(1'b1, "press");
    drain("press_drain");
    repeat (4) @(negedge clk);
    clean_step(1'b0, "release");
    drain("release_drain");
    repeat (4) @(negedge clk);

    // Bounce: every run on s is shorter than the window
    busy_seen = 0;
    din_a = 1'b1;
    repeat (2) begin @(negedge clk); busy_seen |= int'(busy_a); end
    din_a = 1'b0;
    @(negedge clk); busy_seen |= int'(busy_a);
    din_a = 1'b1;
    repeat (3) begin @(negedge clk); busy_seen |= int'(busy_a); end
    din_a = 1'b0;
    repeat (10) begin @(negedge clk); busy_seen |= int'(busy_a); end
    check("bounce_level", {31'd0, level_a}, 32'd0);
    check("bounce_busy_seen", 32'(busy_seen), 32'd1);
    check("bounce_busy_end", {31'd0, busy_a}, 32'd0);

    // Reset mid-qualification: assert after E3, release after E4
    din_a = 1'b1;
    repeat (3) @(negedge clk);
    check("midq_busy_before", {31'd0, busy_a}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("midq_rst_level", {31'd0, level_a}, 32'd0);
    check("midq_rst_busy",  {31'd0, busy_a},  32'd0);
    check("midq_rst_rise",  {31'd0, rise_a},  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    base  = cyc;
    e.is_rise = 1'b1;
    e.cyc     = base + 6;
    sb_a.push_back(e);
    drain("midq_drain");
    check("midq_level_after", {31'd0, level_a}, 32'd1);
    din_a = 1'b0;
    base  = cyc;
    e.is_rise = 1'b0;
    e.cyc     = base + 6;
    sb_a.push_back(e);
    drain("midq_release_drain");
    repeat (2) @(negedge clk);

    // Instance B: three sync stages, single-cycle window
    busy_seen = 0;
    din_b = 1'b1;
    base  = cyc;
    e.is_rise = 1'b1;
    e.cyc     = base + 4;
    sb_b.push_back(e);
    repeat (8) begin @(negedge clk); busy_seen |= int'(busy_b); end
    check("b_busy_never", 32'(busy_seen), 32'd0);
    drain("b_drain");
    check("b_level", {31'd0, level_b}, 32'd1);

    // Downstream toggle flop: reset it, then three clean presses
    rst_n = 1'b0;
    din_b = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    for (int p = 0; p < 3; p++) begin
      din_a = 1'b1;
      e.is_rise = 1'b1;
      e.cyc     = cyc + 6;
      sb_a.push_back(e);
      repeat (10) @(negedge clk);
      din_a = 1'b0;
      e.is_rise = 1'b0;
      e.cyc     = cyc + 6;
      sb_a.push_back(e);
      repeat (10) @(negedge clk);
    end
    drain("tff_drain");
    check("tff_toggles", 32'(tff_toggles), 32'd3);
    check("tff_q", {31'd0, tff_q}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
